frame_threshold_sched: RTL
==========================

# frame_threshold_sched

Per-frame scheduler that sweeps the video colour-threshold filter across up to four programmable colour slots, one slot per video frame. It sits beside the threshold/centre-of-mass pipeline on the vision stream. It drives the filter's low/up thresholds, changing them only between frames. At end of frame it captures the centre-of-mass results into a per-slot result bank, which the CPU reads over an Avalon-MM slave.

## Interface
- NUM_SLOTS, 4, number of colour slots (1-4); slot index is 2 bits
- CAPTURE_TIMEOUT, 1024, cycles allowed from frame_eop to res_valid before the slot is flagged failed
- SCHED_ID, 32'h1234EEE3, constant returned at address 8

- clk  in  1  system clock
- reset_n  in  1  reset; one clock; asynchronous, active-low
- s_chipselect  in  1  MM slave select
- s_read  in  1  MM read strobe
- s_write  in  1  MM write strobe
- s_address  in  4  MM word address
- s_writedata  in  32  MM write data
- s_readdata  out  32  MM read data, registered
- frame_sop  in  1  pulse: accepted start-of-packet beat of a video packet
- frame_eop  in  1  pulse: accepted end-of-packet beat of a video packet
- res_valid  in  1  pulse: res_mass/res_ex/res_ey hold the finished frame's results
- res_mass  in  32  pixel mass of last frame
- res_ex  in  32  raw x moment of last frame
- res_ey  in  32  raw y moment of last frame
- thr_low  out  24  applied lower threshold {R,G,B}
- thr_up  out  24  applied upper threshold {R,G,B}
- active_slot  out  2  slot whose thresholds are applied
- sched_busy  out  1  high in any state other than IDLE

## Operation
- Register map (word addresses):
  - 0 CTRL: W [0] run, [1] oneshot, [11:8] slot enable mask. R adds [16] busy, [19:18] active_slot, [31:24] sweep count.
  - 1 SLOT_SEL: [1:0].
  - 2 SLOT_LOW and 3 SLOT_UP: [23:0] of the selected slot.
  - 4 RES_MASS, 5 RES_EX, 6 RES_EY: result of the selected slot.
  - 7 STATUS: [3:0] fresh flags, [7:4] timeout flags. Both are write-1-to-clear.
  - 8 ID.
  - Unmapped reads return 0.
- Internal in_frame flag: set on frame_sop, cleared on frame_eop. If both arrive in the same cycle, the eop is processed and in_frame ends up 1.
- States:
  - IDLE: when run=1 and the enable mask is non-zero, select the lowest enabled slot and go to APPLY.
  - APPLY: if in_frame=1, stay. Otherwise latch the slot table entry into thr_low/thr_up/active_slot, then go to ARM.
  - ARM: wait for frame_sop, then go to FRAME.
  - FRAME: on frame_eop go to CAPTURE.
  - CAPTURE: on res_valid, write the mass/ex/ey bank of active_slot, set its fresh flag, and go to ADVANCE.
  - ADVANCE: pick the next enabled slot after active_slot, round-robin with wrap.
    - Wrap past the highest enabled slot increments the sweep count (8-bit, wraps 255->0).
    - If oneshot=1 and the sweep wrapped, clear run and go to IDLE.
    - If run=0, go to IDLE.
    - Otherwise go to APPLY.
- Thresholds never change while in_frame=1. A frame_sop that arrives during CAPTURE/ADVANCE/APPLY is simply not measured; APPLY waits for its eop.
- Clearing run mid-sweep is graceful: the current frame completes CAPTURE, then ADVANCE goes to IDLE. Outputs keep their last values.
- Slot table writes while running take effect the next time that slot is applied.
- Enable bits for slots >= NUM_SLOTS are ignored.
- A W1C write and a simultaneous set of the same flag: the set wins.

## Timing
- Reset values: s_readdata 0, thr_low 0, thr_up 0, active_slot 0, sched_busy 0. Also cleared: slot table, result bank, flags, sweep count, CTRL, SLOT_SEL.
- Reset asserted mid-operation returns to IDLE immediately; no capture completes.
- MM reads: s_readdata is valid on the cycle after s_chipselect&s_read. Writes take effect on the next edge.
- APPLY -> thresholds are visible on the cycle after entry when in_frame=0.
- frame_eop -> CAPTURE next cycle. res_valid is accepted in the same cycle it arrives; the bank is readable from the following cycle.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - CAPTURE runs a counter.
  - After CAPTURE_TIMEOUT cycles without res_valid, set the slot's timeout flag, leave its bank unchanged, and go to ADVANCE.
- SCHED_TIMEOUT_EN undefined:
  - No counter; CAPTURE waits indefinitely.
  - Timeout flags read 0.

## Test plan
- Enable mask 4'b0101, slot0 low/up=0x800000/0xFF7F7F, slot2=0x008000/0x7FFF7F, run=1, three frames -> thr_* sequence slot0, slot2, slot0; sweep count=1 after frame 2.
- res_valid with mass=0x1234 after frame on slot2 -> RES_MASS(slot2)=0x00001234; STATUS=0x04; write 0x04 to STATUS -> 0x00.
- SLOT_UP write during a frame -> thr_up unchanged until after frame_eop and the next APPLY.
- frame_sop arriving during CAPTURE -> thresholds held until that frame's eop; no result written for it.
- oneshot=1, mask 4'b0011 -> exactly two frames measured, then busy=0 and run reads 0.
- With SCHED_TIMEOUT_EN and CAPTURE_TIMEOUT=16, no res_valid -> after 16 cycles STATUS[4+slot]=1 and the scheduler advances. Assert reset_n mid-FRAME -> all outputs 0 on the next sample.

Source files
------------

// File: rtl/frame_threshold_sched_if.sv
// frame_threshold_sched_if: Avalon-MM slave bus used by the CPU to program the
// threshold scheduler and read back its per-slot results.
interface frame_threshold_sched_if;
   logic        s_chipselect;
   logic        s_read;
   logic        s_write;
   logic [3:0]  s_address;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;
   modport master (output s_chipselect, s_read, s_write, s_address, s_writedata, input s_readdata);
   modport slave (input s_chipselect, s_read, s_write, s_address, s_writedata, output s_readdata);
endinterface

// File: rtl/frame_threshold_sched.sv
// frame_threshold_sched: sweeps colour-threshold slots one per video frame and banks centre-of-mass results.
// Define SCHED_TIMEOUT_EN to abandon a capture after CAPTURE_TIMEOUT cycles without res_valid.
module frame_threshold_sched #(
   parameter int          NUM_SLOTS       = 4,
   parameter int          CAPTURE_TIMEOUT = 1024,
   parameter logic [31:0] SCHED_ID        = 32'h1234EEE3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   frame_threshold_sched_if.slave mm,
   input  logic                   frame_sop,
   input  logic                   frame_eop,
   input  logic                   res_valid,
   input  logic [31:0]            res_mass,
   input  logic [31:0]            res_ex,
   input  logic [31:0]            res_ey,
   output logic [23:0]            thr_low,
   output logic [23:0]            thr_up,
   output logic [1:0]             active_slot,
   output logic                   sched_busy
);
   typedef enum logic [2:0] {IDLE, APPLY, ARM, FRAME, CAPTURE, ADVANCE} state_t;
   state_t      state;
   logic        run, oneshot, in_frame, wr, rd, nxt_wrap;
   logic [3:0]  mask, en, fresh, tmo_rd;
   logic [7:0]  clr;
   logic [1:0]  slot_sel, sel_slot, low_slot, nxt_slot;
   logic [7:0]  sweep;
   logic [23:0] slot_low [4];
   logic [23:0] slot_up [4];
   logic [31:0] bank_mass [4];
   logic [31:0] bank_ex [4];
   logic [31:0] bank_ey [4];
   logic [31:0] rdata;
`ifdef SCHED_TIMEOUT_EN
   localparam int CW = $clog2(CAPTURE_TIMEOUT + 1);
   logic [3:0]    tmo;
   logic [CW-1:0] cnt;
   assign tmo_rd = tmo;
`else
   assign tmo_rd = 4'd0;
`endif
   assign en  = mask & 4'((1 << NUM_SLOTS) - 1);
   assign wr  = mm.s_chipselect & mm.s_write;
   assign rd  = mm.s_chipselect & mm.s_read;
   assign clr = (wr && mm.s_address == 4'd7) ? mm.s_writedata[7:0] : 8'd0;
   always_comb begin
      low_slot = 2'd0;
      nxt_slot = active_slot;
      nxt_wrap = 1'b1;
      for (int i = 3; i >= 0; i--) if (en[i]) low_slot = 2'(i);
      // Scanning downward leaves the nearest enabled slot after active_slot; index wrap marks a sweep end.
      for (int i = 4; i >= 1; i--) if (en[active_slot + 2'(i)]) begin
         nxt_slot = active_slot + 2'(i);
         nxt_wrap = active_slot + 2'(i) <= active_slot;
      end
   end
   always_comb begin
      case (mm.s_address)
         4'd0:    rdata = {sweep, 4'd0, active_slot, 1'b0, sched_busy, 4'd0, mask, 6'd0, oneshot, run};
         4'd1:    rdata = {30'd0, slot_sel};
         4'd2:    rdata = {8'd0, slot_low[slot_sel]};
         4'd3:    rdata = {8'd0, slot_up[slot_sel]};
         4'd4:    rdata = bank_mass[slot_sel];
         4'd5:    rdata = bank_ex[slot_sel];
         4'd6:    rdata = bank_ey[slot_sel];
         4'd7:    rdata = {24'd0, tmo_rd, fresh};
         4'd8:    rdata = SCHED_ID;
         default: rdata = 32'd0;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         mm.s_readdata  <= 32'd0;
         thr_low        <= 24'd0;
         thr_up         <= 24'd0;
         active_slot    <= 2'd0;
         sched_busy     <= 1'b0;
         run            <= 1'b0;
         oneshot        <= 1'b0;
         mask           <= 4'd0;
         slot_sel       <= 2'd0;
         sel_slot       <= 2'd0;
         sweep          <= 8'd0;
         fresh          <= 4'd0;
         in_frame       <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            slot_low[i]  <= 24'd0;
            slot_up[i]   <= 24'd0;
            bank_mass[i] <= 32'd0;
            bank_ex[i]   <= 32'd0;
            bank_ey[i]   <= 32'd0;
         end
`ifdef SCHED_TIMEOUT_EN
         tmo <= 4'd0;
         cnt <= '0;
`endif
      end else begin
         in_frame <= frame_sop | (in_frame & ~frame_eop);
         if (rd) mm.s_readdata <= rdata;
         if (wr) begin
            case (mm.s_address)
               4'd0:    {mask, oneshot, run} <= {mm.s_writedata[11:8], mm.s_writedata[1:0]};
               4'd1:    slot_sel <= mm.s_writedata[1:0];
               4'd2:    slot_low[slot_sel] <= mm.s_writedata[23:0];
               4'd3:    slot_up[slot_sel] <= mm.s_writedata[23:0];
               default: ;
            endcase
         end
         // Clears land first so a same-cycle flag set below overrides them.
         fresh <= fresh & ~clr[3:0];
`ifdef SCHED_TIMEOUT_EN
         tmo <= tmo & ~clr[7:4];
`endif
         case (state)
            IDLE: if (run && en != 4'd0) begin
               sel_slot   <= low_slot;
               sched_busy <= 1'b1;
               state      <= APPLY;
            end
            APPLY: if (!in_frame) begin
               thr_low     <= slot_low[sel_slot];
               thr_up      <= slot_up[sel_slot];
               active_slot <= sel_slot;
               state       <= ARM;
            end
            ARM: if (frame_sop) state <= FRAME;
            FRAME: if (frame_eop) begin
               state <= CAPTURE;
`ifdef SCHED_TIMEOUT_EN
               cnt <= '0;
`endif
            end
            CAPTURE: if (res_valid) begin
               bank_mass[active_slot] <= res_mass;
               bank_ex[active_slot]   <= res_ex;
               bank_ey[active_slot]   <= res_ey;
               fresh[active_slot]     <= 1'b1;
               state                  <= ADVANCE;
            end
`ifdef SCHED_TIMEOUT_EN
            else if (cnt == CW'(CAPTURE_TIMEOUT - 1)) begin
               tmo[active_slot] <= 1'b1;
               state            <= ADVANCE;
            end else cnt <= cnt + 1'b1;
`endif
            ADVANCE: begin
               sel_slot <= nxt_slot;
               if (nxt_wrap && en != 4'd0) sweep <= sweep + 8'd1;
               if ((oneshot && nxt_wrap) || !run || en == 4'd0) begin
                  if (oneshot && nxt_wrap) run <= 1'b0;
                  sched_busy <= 1'b0;
                  state      <= IDLE;
               end else state <= APPLY;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
